izigzag_stream: RTL and testbench

//  Inverse zigzag reorder: the receive-side counterpart of the 8x8 zigzag block.
//  - Accepts one 8x8 block as 64 coefficients, one per beat, in JPEG zigzag scan order.
//  - Rebuilds the raster block in an internal buffer, then emits it as 8 row beats, row 0 first.
//  - Sits between the entropy/coefficient stream and the row-oriented IDCT datapath.

---
 rtl/izigzag_stream_if.sv | 27 ++
 rtl/izigzag_stream.sv | 112 +++++++++++
 tb/tb_izigzag_stream.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/izigzag_stream_if.sv
// Stream bundle for the inverse zigzag block: zigzag-ordered coefficient
// input on one side, raster rows out on the other.
interface izigzag_stream_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic           in_eob;
  logic           out_valid;
  logic           out_ready;
  logic [8*N-1:0] out_row;
  logic [2:0]     out_row_idx;
  logic           out_last;

  // Environment side: feeds coefficients and consumes rows.
  modport master (
    output in_valid, in_data, in_eob, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, out_last
  );

  // Block side.
  modport slave (
    input  in_valid, in_data, in_eob, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, out_last
  );
endinterface

// File: rtl/izigzag_stream.sv
// Inverse zigzag reorder: 64 zigzag-ordered coefficients in, 8 raster rows out.
// Define IZZ_EOB_EN to allow early end-of-block with zero-filled unwritten positions.
module izigzag_stream #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  izigzag_stream_if.slave   bus
);

  typedef enum logic {FILL, DRAIN} state_t;

  // Zigzag scan index -> raster position (row*8 + col), standard JPEG order.
  localparam logic [5:0] ZZ_LUT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  state_t       state_q, state_d;
  logic [5:0]   zz_cnt;
  logic [2:0]   row_cnt;
  logic [5:0]   wr_pos;
  logic         in_fire;
  logic         out_fire;
  logic         last_beat;
  logic         last_row;
  logic [N-1:0] coef_buf [64];

  // Fire terms come from the state register, not from the ready/valid outputs,
  // so the handshake outputs have no combinational path back into themselves.
  assign in_fire  = bus.in_valid  && (state_q == FILL);
  assign out_fire = bus.out_ready && (state_q == DRAIN);
  assign wr_pos   = ZZ_LUT[zz_cnt];
  assign last_row = (row_cnt == 3'd7);

`ifdef IZZ_EOB_EN
  logic [63:0] mask;
  assign last_beat = (zz_cnt == 6'd63) || bus.in_eob;
`else
  logic unused_eob;
  assign unused_eob = bus.in_eob;
  assign last_beat  = (zz_cnt == 6'd63);
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      FILL: begin
        bus.in_ready = 1'b1;
        if (in_fire && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        if (out_fire && last_row) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      zz_cnt  <= '0;
      row_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire)  zz_cnt  <= last_beat ? 6'd0 : zz_cnt + 6'd1;
      if (out_fire) row_cnt <= row_cnt + 3'd1;
    end
  end

`ifdef IZZ_EOB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (in_fire) begin
      mask[wr_pos] <= 1'b1;
    end else if (out_fire && last_row) begin
      mask <= '0;
    end
  end
`endif

  // NOTE: the coefficient buffer is deliberately not reset; a full block (or
  // the written mask) always covers every position before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) coef_buf[wr_pos] <= bus.in_data;
  end

  always_comb begin
    bus.out_row = '0;
    for (int c = 0; c < 8; c++) begin
`ifdef IZZ_EOB_EN
      bus.out_row[N*c +: N] = mask[{row_cnt, 3'(c)}] ? coef_buf[{row_cnt, 3'(c)}] : '0;
`else
      bus.out_row[N*c +: N] = coef_buf[{row_cnt, 3'(c)}];
`endif
    end
  end

  assign bus.out_row_idx = row_cnt;
  assign bus.out_last    = (state_q == DRAIN) && last_row;

endmodule

// File: tb/tb_izigzag_stream.sv
// Directed bench for izigzag_stream: ramp, back-pressure, back-to-back blocks,
// reset mid-fill, and (with IZZ_EOB_EN) early end-of-block.
module tb_izigzag_stream;

  localparam int N   = 8;
  localparam int TMO = 300;

  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  izigzag_stream_if #(.N(N)) bus ();

  izigzag_stream #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int first_wait;
  logic [8*N-1:0] got_rows [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] beat_val(input int base, input bit inv, input int k);
    return inv ? 8'(255 - (base + k)) : 8'(base + k);
  endfunction

  // Expected raster row r after beats 0..n-1; unwritten positions read 0.
  function automatic logic [63:0] exp_row(input int r, input int base, input bit inv, input int n);
    logic [63:0] v;
    logic [5:0]  pos;
    v = '0;
    for (int k = 0; k < n; k++) begin
      pos = ZZ[k];
      if (int'(pos[5:3]) == r) v[8*pos[2:0] +: 8] = beat_val(base, inv, k);
    end
    return v;
  endfunction

  task automatic drive_block(input int base, input bit inv, input int n, input bit eob, input bit hold);
    int t;
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beat_val(base, inv, k);
      bus.in_eob   = eob && (k == n - 1);
      t = 0;
      while (!bus.in_ready && t < TMO) begin
        @(negedge clk);
        t++;
      end
      if (k == 0) first_wait = t;
      if (t >= TMO) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_eob = 1'b0;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic collect_block(input int base, input bit inv, input int n, input int stall_row);
    int t;
    logic [63:0] held;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      t = 0;
      while (!bus.out_valid && t < TMO) begin
        @(negedge clk);
        t++;
      end
      if (t >= TMO) begin
        check("out_valid_timeout", 64'd0, 64'd1);
        break;
      end
      check($sformatf("row_idx%0d", r), 64'(bus.out_row_idx), 64'(r));
      check($sformatf("last%0d", r), 64'(bus.out_last), 64'(r == 7));
      check($sformatf("row%0d", r), bus.out_row, exp_row(r, base, inv, n));
      got_rows[r] = bus.out_row;
      if (r == stall_row) begin
        bus.out_ready = 1'b0;
        held = bus.out_row;
        repeat (5) begin
          @(negedge clk);
          check("stall_row", bus.out_row, held);
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_idx", 64'(bus.out_row_idx), 64'(r));
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_row_idx"}, 64'(bus.out_row_idx), 64'd0);
  endtask

  task automatic check_ramp_consts(input string tag);
    check({tag, "_r0"}, got_rows[0], 64'h1C1B0F0E_06050100);
    check({tag, "_r1"}, got_rows[1], 64'h2A1D1A10_0D070402);
    check({tag, "_r7"}, got_rows[7], 64'h3F3E3A39_31302423);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_eob    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst_low");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst");

    // Ramp.
    drive_block(0, 1'b0, 64, 1'b0, 1'b0);
    collect_block(0, 1'b0, 64, -1);
    check_ramp_consts("ramp");
    check_idle("after_ramp");

    // Back-pressure on row 3.
    drive_block(0, 1'b0, 64, 1'b0, 1'b0);
    collect_block(0, 1'b0, 64, 3);
    check_ramp_consts("bp");

    // Back-to-back blocks with in_valid held high.
    fork
      begin
        drive_block(0, 1'b0, 64, 1'b0, 1'b1);
        drive_block(0, 1'b1, 64, 1'b0, 1'b0);
      end
      begin
        collect_block(0, 1'b0, 64, -1);
        check_ramp_consts("b2b_a");
        collect_block(0, 1'b1, 64, -1);
        check("b2b_b_r0", got_rows[0], 64'hE3E4F0F1_F9FAFEFF);
      end
    join
    check("b2b_gap", 64'(first_wait), 64'd8);

    // Reset in the middle of a fill.
    drive_block(0, 1'b0, 30, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    drive_block(0, 1'b0, 64, 1'b0, 1'b0);
    collect_block(0, 1'b0, 64, -1);
    check_ramp_consts("midrst");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    check("midrst_no_extra", 64'(extra), 64'd0);

`ifdef IZZ_EOB_EN
    // Early end-of-block after six beats.
    drive_block(8'h0A, 1'b0, 6, 1'b1, 1'b0);
    collect_block(8'h0A, 1'b0, 6, -1);
    check("eob_r0", got_rows[0], 64'h00000000_000F0B0A);
    check("eob_r1", got_rows[1], 64'h00000000_00000E0C);
    check("eob_r2", got_rows[2], 64'h00000000_0000000D);
    check("eob_r7", got_rows[7], 64'h0);
    drive_block(0, 1'b0, 64, 1'b0, 1'b0);
    collect_block(0, 1'b0, 64, -1);
    check_ramp_consts("eob_next");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
